// File: rtl/rx_lp_pkg.sv
// Shared types for the D-PHY receive-side LP lane controller: lane state codes and LP line values.
// Escape codes stay reserved even in builds without RX_LP_ESC_DETECT_EN.
package rx_lp_pkg;

   // Nine states do not fit three bits, so the code space is four bits wide.
   typedef enum logic [3:0] {
      ST_STOP     = 4'd0,
      ST_HS_RQST  = 4'd1,
      ST_HS_PRPR  = 4'd2,
      ST_HS_TERM  = 4'd3,
      ST_HS_RX    = 4'd4,
      ST_ESC_RQST = 4'd5,
      ST_ESC_BRDG = 4'd6,
      ST_ESC_ACK  = 4'd7,
      ST_ESC_MODE = 4'd8
   } lane_state_e;

   typedef logic [1:0] line_t;

   localparam line_t LP00 = 2'b00;
   localparam line_t LP01 = 2'b01;
   localparam line_t LP10 = 2'b10;
   localparam line_t LP11 = 2'b11;

endpackage

// File: rtl/rx_lp_lane_ctrl_if.sv
// Bundle between the LP line receivers (master) and the lane controller (slave).
interface rx_lp_lane_ctrl_if #(
   parameter int NUM_LANES = 4
);
   logic [NUM_LANES-1:0] lp_dp;
   logic [NUM_LANES-1:0] lp_dn;
   logic [NUM_LANES-1:0] lane_enable;
   logic [NUM_LANES-1:0] hs_term_en;
   logic [NUM_LANES-1:0] hs_rx_en;
   logic [NUM_LANES-1:0] stop_state;
   logic [NUM_LANES-1:0] err_ctrl;
   logic [NUM_LANES-1:0] esc_mode;
   logic                 all_stop;

   modport master (
      output lp_dp, lp_dn, lane_enable,
      input  hs_term_en, hs_rx_en, stop_state, err_ctrl, esc_mode, all_stop
   );

   modport slave (
      input  lp_dp, lp_dn, lane_enable,
      output hs_term_en, hs_rx_en, stop_state, err_ctrl, esc_mode, all_stop
   );
endinterface

// File: rtl/rx_lp_lane_fsm.sv
// One lane's LP state machine with its dwell counter; escape entry is built only with
// RX_LP_ESC_DETECT_EN defined.
module rx_lp_lane_fsm
   import rx_lp_pkg::*;
#(
   parameter int T_TERM_EN = 2,
   parameter int T_SETTLE  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic lp_dp_i,
   input  logic lp_dn_i,
   input  logic lane_enable_i,
   output logic hs_term_en_o,
   output logic hs_rx_en_o,
   output logic stop_state_o,
   output logic err_ctrl_o,
   output logic esc_mode_o
);

   localparam int CNT_TOP = (T_TERM_EN > T_SETTLE) ? T_TERM_EN : T_SETTLE;
   localparam int CNT_W   = (CNT_TOP > 0) ? $clog2(CNT_TOP + 1) : 1;
   localparam logic [CNT_W-1:0] TERM_CNT   = CNT_W'(T_TERM_EN);
   localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(T_SETTLE);

   lane_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   line_t            line;

   assign line = {lp_dp_i, lp_dn_i};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_STOP;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      if (!lane_enable_i) begin
         state_d = ST_STOP;
      end else begin
         case (state_q)
            ST_STOP: begin
               if (line == LP01)      state_d = ST_HS_RQST;
               else if (line == LP00) err_d = 1'b1;
`ifdef RX_LP_ESC_DETECT_EN
               else if (line == LP10) state_d = ST_ESC_RQST;
`endif
            end
            ST_HS_RQST: begin
               if (line == LP00)      state_d = ST_HS_PRPR;
               else if (line == LP11) state_d = ST_STOP;
               else if (line == LP10) begin state_d = ST_STOP; err_d = 1'b1; end
            end
            ST_HS_PRPR: begin
               if (line != LP00)           begin state_d = ST_STOP; err_d = 1'b1; end
               else if (cnt_q == TERM_CNT) state_d = ST_HS_TERM;
            end
            ST_HS_TERM: begin
               if (line == LP11) begin state_d = ST_STOP; err_d = 1'b1; end
               else if (line == LP00 && cnt_q == SETTLE_CNT) state_d = ST_HS_RX;
            end
            ST_HS_RX: begin
               if (line == LP11) state_d = ST_STOP;
            end
`ifdef RX_LP_ESC_DETECT_EN
            ST_ESC_RQST: begin
               if (line == LP00)      state_d = ST_ESC_BRDG;
               else if (line == LP11) state_d = ST_STOP;
               else if (line == LP01) begin state_d = ST_STOP; err_d = 1'b1; end
            end
            ST_ESC_BRDG: begin
               if (line == LP01)      state_d = ST_ESC_ACK;
               else if (line == LP11) state_d = ST_STOP;
               else if (line == LP10) begin state_d = ST_STOP; err_d = 1'b1; end
            end
            ST_ESC_ACK: begin
               if (line == LP00)      state_d = ST_ESC_MODE;
               else if (line == LP11) state_d = ST_STOP;
               else if (line == LP10) begin state_d = ST_STOP; err_d = 1'b1; end
            end
            ST_ESC_MODE: begin
               if (line == LP11) state_d = ST_STOP;
            end
`endif
            default: state_d = ST_STOP;
         endcase
      end
      // Counter restarts on every state change and sticks at all-ones while dwelling.
      if (!lane_enable_i || state_d != state_q) cnt_d = '0;
      else if (cnt_q != {CNT_W{1'b1}})          cnt_d = cnt_q + 1'b1;
   end

   assign hs_term_en_o = (state_q == ST_HS_TERM) || (state_q == ST_HS_RX);
   assign hs_rx_en_o   = (state_q == ST_HS_RX);
   assign stop_state_o = (state_q == ST_STOP);
   assign err_ctrl_o   = err_q;
`ifdef RX_LP_ESC_DETECT_EN
   assign esc_mode_o   = (state_q == ST_ESC_MODE);
`else
   assign esc_mode_o   = 1'b0;
`endif

endmodule

// File: rtl/rx_lp_lane_ctrl.sv
// N-lane receive-side LP controller: one independent lane FSM per lane plus the all_stop summary.
// Escape detection is enabled by defining RX_LP_ESC_DETECT_EN.
module rx_lp_lane_ctrl #(
   parameter int NUM_LANES = 4,
   parameter int T_TERM_EN = 2,
   parameter int T_SETTLE  = 4
) (
   input logic              clk,
   input logic              rst,
   rx_lp_lane_ctrl_if.slave bus
);

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      rx_lp_lane_fsm #(
         .T_TERM_EN (T_TERM_EN),
         .T_SETTLE  (T_SETTLE)
      ) u_fsm (
         .clk           (clk),
         .rst           (rst),
         .lp_dp_i       (bus.lp_dp[g]),
         .lp_dn_i       (bus.lp_dn[g]),
         .lane_enable_i (bus.lane_enable[g]),
         .hs_term_en_o  (bus.hs_term_en[g]),
         .hs_rx_en_o    (bus.hs_rx_en[g]),
         .stop_state_o  (bus.stop_state[g]),
         .err_ctrl_o    (bus.err_ctrl[g]),
         .esc_mode_o    (bus.esc_mode[g])
      );
   end

   // Disabled lanes do not hold all_stop low; with no lane enabled it reads 0.
   assign bus.all_stop = (|bus.lane_enable) & (&(bus.stop_state | ~bus.lane_enable));

endmodule
